// File: rtl/serial_alu_seq_if.sv
// Handshake and operand/result bundle for the bit-serial ALU sequencer.
// The master issues operations; the slave (sequencer) returns results and flags.
interface serial_alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [3:0]       ctrl;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;

    modport master (
        output start, src1, src2, ctrl,
        input  busy, done, result, zero, cout, overflow
    );

    modport slave (
        input  start, src1, src2, ctrl,
        output busy, done, result, zero, cout, overflow
    );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: runs one 1-bit ALU slice over WIDTH bits, LSB first,
// carrying between bits and assembling the result and zero/carry/overflow flags.
module serial_alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input logic             clk,
    input logic             rst,
    serial_alu_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, result_q;
    logic [3:0]       ctrl_q;
    logic [CNT_W-1:0] idx_q;
    logic             carry_q;
    logic             busy_q, done_q, zero_q, cout_q, ovf_q;

    logic             a_bit, b_bit, slice_sum, slice_cout, slice_res, ovf_raw;
    logic [1:0]       op;
    logic [WIDTH-1:0] full, fin_res;
    logic             fin_cout, fin_ovf;

    // One-bit ALU slice; SLT forces the subtract path, the less input is tied to 0.
    always_comb begin
        op         = (ctrl_q == 4'b0111) ? 2'b10 : ctrl_q[1:0];
        a_bit      = a_q[idx_q] ^ ctrl_q[3];
        b_bit      = b_q[idx_q] ^ ctrl_q[2];
        slice_sum  = a_bit ^ b_bit ^ carry_q;
        slice_cout = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
        case (op)
            2'b00:   slice_res = a_bit & b_bit;
            2'b01:   slice_res = a_bit | b_bit;
            2'b10:   slice_res = slice_sum;
            default: slice_res = 1'b0;
        endcase
    end

    // Final result/flags, valid while the MSB is being processed.
    always_comb begin
        full            = res_q;
        full[WIDTH-1]   = slice_res;
        ovf_raw         = carry_q ^ slice_cout;
        fin_res         = '0;
        fin_cout        = 1'b0;
        fin_ovf         = 1'b0;
        case (ctrl_q)
            4'b0010, 4'b0110: begin
                fin_res  = full;
                fin_cout = slice_cout;
                fin_ovf  = ovf_raw;
            end
            4'b0111: begin
                fin_res[0] = slice_sum ^ ovf_raw;
                fin_cout   = slice_cout;
            end
            4'b0000, 4'b0001, 4'b1100, 4'b1101: fin_res = full;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_q     <= bus.src1;
                        b_q     <= bus.src2;
                        ctrl_q  <= bus.ctrl;
                        idx_q   <= '0;
                        carry_q <= bus.ctrl[2];
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    res_q[idx_q] <= slice_res;
                    carry_q      <= slice_cout;
                    if (idx_q == LastIdx) begin
                        result_q <= fin_res;
                        zero_q   <= (fin_res == '0);
                        cout_q   <= fin_cout;
                        ovf_q    <= fin_ovf;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Randomized self-checking bench for serial_alu_seq against an arithmetic model
// of the ALU operations, with directed handshake, back-to-back and reset cases.
module tb_serial_alu_seq;

    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    serial_alu_seq_if #(.WIDTH(WIDTH)) bus ();

    serial_alu_seq #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [3:0] c, output logic [WIDTH-1:0] res,
                         output logic co, output logic ov);
        logic [WIDTH:0] add_w, sub_w;
        add_w = {1'b0, a} + {1'b0, b};
        sub_w = {1'b0, a} + {1'b0, ~b} + 1;
        res = '0;
        co  = 1'b0;
        ov  = 1'b0;
        case (c)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b1100: res = ~(a | b);
            4'b1101: res = ~(a & b);
            4'b0010: begin
                res = add_w[WIDTH-1:0];
                co  = add_w[WIDTH];
                ov  = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0110: begin
                res = sub_w[WIDTH-1:0];
                co  = sub_w[WIDTH];
                ov  = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: begin
                res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
                co  = sub_w[WIDTH];
            end
            default: ;
        endcase
    endtask

    // Called at a falling edge with the DUT idle; start is accepted at the next rising edge.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [3:0] c, input int inject_at);
        logic [WIDTH-1:0] exp_res;
        logic             exp_co, exp_ov;
        int               k, busy_err;
        model(a, b, c, exp_res, exp_co, exp_ov);
        bus.start = 1'b1;
        bus.src1  = a;
        bus.src2  = b;
        bus.ctrl  = c;
        @(negedge clk);
        bus.start = 1'b0;
        bus.src1  = $urandom;
        bus.src2  = $urandom;
        bus.ctrl  = 4'($urandom);
        k = 1;
        busy_err = 0;
        while (bus.done !== 1'b1 && k < WIDTH + 20) begin
            if (bus.busy !== 1'b1) busy_err++;
            bus.start = (k == inject_at);
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        if (bus.busy !== 1'b1) busy_err++;
        check("latency", 64'(k), 64'(WIDTH + 1));
        check("busy_run", 64'(busy_err), 64'd0);
        check("result", 64'(bus.result), 64'(exp_res));
        check("zero", 64'(bus.zero), 64'(exp_res == '0));
        check("cout", 64'(bus.cout), 64'(exp_co));
        check("overflow", 64'(bus.overflow), 64'(exp_ov));
        @(negedge clk);
        check("done_pulse", 64'(bus.done), 64'd0);
        check("busy_end", 64'(bus.busy), 64'd0);
        check("result_hold", 64'(bus.result), 64'(exp_res));
    endtask

    logic [3:0] codes [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101};

    initial begin
        int seen_done;
        logic [3:0] c;
        bus.start = 1'b0;
        bus.src1  = '0;
        bus.src2  = '0;
        bus.ctrl  = '0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;  // start during reset must be ignored
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_zero", 64'(bus.zero), 64'd1);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_ovf", 64'(bus.overflow), 64'd0);
        @(negedge clk);
        check("rst_start_ign", 64'(bus.busy), 64'd0);

        run_op(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 10);  // stray start at cycle 10
        run_op(32'd5, 32'd5, 4'b0110, 0);                    // back-to-back
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, 0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 4'b0111, 0);
        run_op(32'h0, 32'h0, 4'b1100, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_FFFF, 4'b1101, 0);
        run_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000, 0);
        run_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0001, 0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 4'b1010, 0);   // undefined code

        // Reset mid-SUB: abort with no done pulse.
        bus.start = 1'b1;
        bus.src1  = 32'd100;
        bus.src2  = 32'd7;
        bus.ctrl  = 4'b0110;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_zero", 64'(bus.zero), 64'd1);
        seen_done = 0;
        for (int i = 0; i < WIDTH + 5; i++) begin
            if (bus.done === 1'b1) seen_done++;
            @(negedge clk);
        end
        check("abort_nodone", 64'(seen_done), 64'd0);
        run_op(32'd100, 32'd7, 4'b0110, 0);

        for (int i = 0; i < 24; i++) begin
            c = ($urandom_range(0, 7) == 7) ? 4'($urandom) : codes[$urandom_range(0, 6)];
            run_op($urandom, $urandom, c, $urandom_range(0, 1) ? int'($urandom_range(2, 30)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Bit-serial sequencer that drives a single 1-bit ALU slice (alu_top) over a WIDTH-bit operand pair, one bit per clock, LSB first.
- Latches operands and ALU control, generates the per-bit slice controls, holds the inter-bit carry, and assembles the WIDTH-bit result plus zero/carry/overflow flags.
- Sits between the ID/EX operand source and the EX result mux as the area-reduced alternative to the parallel ripple ALU.
- Uses start/busy/done handshaking.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- CNT_W, 5, bit-index counter width; must satisfy 2^CNT_W ≥ WIDTH.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  request; sampled only when busy_o=0.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- ctrl_i  input  4  ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND.
- busy_o  output  1  high from the cycle after start is accepted until done_o.
- done_o  output  1  one-cycle pulse; result_o and flags are valid in that cycle.
- result_o  output  WIDTH  result; held until the next accepted start.
- zero_o  output  1  result_o == 0.
- cout_o  output  1  carry out of bit WIDTH-1 (ADD/SUB/SLT only, else 0).
- overflow_o  output  1  signed overflow (ADD/SUB only, else 0).

Behaviour:
- Reset is synchronous and active-high on clk_i.
  - On rst_i: state=IDLE; busy_o, done_o, cout_o, overflow_o = 0; result_o = 0; zero_o = 1; counter and carry cleared.
  - Reset mid-operation aborts immediately; no done_o pulse is produced.
- Slice controls are derived from the latched ctrl:
  - A_invert = ctrl[3], B_invert = ctrl[2].
  - operation = ctrl[1:0], except SLT, which drives operation=2'b10 (subtract) on every bit.
  - Initial cin = B_invert.
  - Slice less input is tied to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start_i=1, latch src1/src2/ctrl, set bit index=0, carry=cin_init, go to RUN. Otherwise remain.
  - RUN: each cycle, feed slice bit[idx] and store the slice result into result shift register bit idx. Register carry ← slice cout. At idx=WIDTH-1, capture carry_in_msb (carry entering the MSB) and cout, then go to DONE. Otherwise idx+1.
  - DONE: drive done_o=1 for exactly one cycle, update output registers, return to IDLE. A new start can be accepted in the following cycle.
- Latency: start accepted at edge N → done_o high in cycle N+WIDTH+1 (33 for WIDTH=32). busy_o=1 throughout RUN and DONE.
- Output and flag rules:
  - overflow = carry_in_msb XOR cout_msb for ADD/SUB.
  - SLT: set = sum_msb XOR overflow; result_o = {WIDTH-1 zeros, set}; overflow_o = 0; cout_o = subtract carry.
  - Logical ops: cout_o = 0 and overflow_o = 0.
  - Undefined ctrl codes: result_o = 0, flags = 0 (zero_o = 1), done_o still pulses.
- start_i while busy_o=1 is ignored with no queuing. Operand changes during RUN have no effect.
- start_i in the same cycle as rst_i: reset wins.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, start at cycle 0 → done_o in cycle 33, result 0x80000000, overflow_o=1, cout_o=0, zero_o=0.
- SUB 5 − 5 → result 0x00000000, zero_o=1, cout_o=1, overflow_o=0. Then ADD 0xFFFFFFFF + 1 → result 0, cout_o=1, overflow_o=0.
- SLT 0xFFFFFFFF vs 0x00000001 → result 1. SLT 0x7FFFFFFF vs 0x80000000 → result 0 (overflow-corrected).
- NOR 0, 0 → 0xFFFFFFFF. NAND 0xFFFFFFFF, 0x0000FFFF → 0xFFFF0000. AND/OR with 0xF0F0F0F0, 0x0FF00FF0 → 0x00F000F0 / 0xFFF0FFF0. All logical ops: cout_o=0, overflow_o=0.
- Second start_i pulsed at cycle 10 of an ADD → ignored, single done_o at 33, busy_o continuous 1..33. Back-to-back start accepted at cycle 34.
- rst_i asserted at cycle 15 of a SUB → next cycle busy_o=0, result_o=0, zero_o=1, no done_o. A fresh start afterwards completes normally.
